// File: rtl/mask_generator_pipe.sv
// mask_generator_pipe: 4-stage RGB change-mask generator with a causal run-length filter and per-frame foreground count.
// Define MASK_HYST_EN to add the threshold_lo hysteresis input.
module mask_generator_pipe #(
  parameter int RB_W    = 5,
  parameter int G_W     = 6,
  parameter int MIN_RUN = 2,
  parameter int CNT_W   = 20
) (
  input  logic             clk_25,
  input  logic             rst_n,
  input  logic [31:0]      threshold,
`ifdef MASK_HYST_EN
  input  logic [31:0]      threshold_lo,
`endif
  input  logic             read,
  input  logic [9:0]       sync_x,
  input  logic [9:0]       sync_y,
  input  logic [RB_W-1:0]  ccd_r,
  input  logic [G_W-1:0]   ccd_g,
  input  logic [RB_W-1:0]  ccd_b,
  input  logic [RB_W-1:0]  dvi_r,
  input  logic [G_W-1:0]   dvi_g,
  input  logic [RB_W-1:0]  dvi_b,
  output logic             valid,
  output logic             mask,
  output logic [9:0]       mask_x,
  output logic [9:0]       mask_y,
  output logic [CNT_W-1:0] fg_count_frame,
  output logic             frame_done
);
  localparam int SH    = G_W - RB_W;
  localparam int SQ_W  = 2 * G_W;
  localparam int SUM_W = 2 * G_W + 2;
  localparam int CMP_W = (SUM_W > 32) ? SUM_W : 32;
  localparam int RUN_W = $clog2(MIN_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [G_W-1:0] absdiff(input logic [G_W-1:0] a, input logic [G_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // Red/blue are scaled up to green's range so all channels weigh equally.
  logic [G_W-1:0] cr, cb, rr, rb;
  assign cr = G_W'(ccd_r) << SH;
  assign cb = G_W'(ccd_b) << SH;
  assign rr = G_W'(dvi_r) << SH;
  assign rb = G_W'(dvi_b) << SH;

  logic           v1;
  logic [9:0]     x1, y1;
  logic [G_W-1:0] d1_r, d1_g, d1_b;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      d1_r <= '0;
      d1_g <= '0;
      d1_b <= '0;
    end else begin
      v1   <= read;
      x1   <= sync_x;
      y1   <= sync_y;
      d1_r <= absdiff(cr, rr);
      d1_g <= absdiff(ccd_g, dvi_g);
      d1_b <= absdiff(cb, rb);
    end
  end

  logic [SQ_W-1:0]  sq_r, sq_g, sq_b;
  logic [SUM_W-1:0] sum_c;
  assign sq_r  = SQ_W'(d1_r) * SQ_W'(d1_r);
  assign sq_g  = SQ_W'(d1_g) * SQ_W'(d1_g);
  assign sq_b  = SQ_W'(d1_b) * SQ_W'(d1_b);
  assign sum_c = SUM_W'(sq_r) + SUM_W'(sq_g) + SUM_W'(sq_b);

  logic             v2;
  logic [9:0]       x2, y2;
  logic [SUM_W-1:0] sum2;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      x2   <= '0;
      y2   <= '0;
      sum2 <= '0;
    end else begin
      v2   <= v1;
      x2   <= x1;
      y2   <= y1;
      sum2 <= sum_c;
    end
  end

  logic [31:0] thr_sel;
  logic        raw_c;
  assign raw_c = CMP_W'(sum2) > CMP_W'(thr_sel);

`ifdef MASK_HYST_EN
  // Last valid pixel seen at this stage; lowers the threshold while a line stays foreground.
  logic       hyst_fg;
  logic [9:0] hyst_y;

  always_comb begin
    thr_sel = threshold;
    if (hyst_fg && (x2 != '0) && (y2 == hyst_y))
      thr_sel = threshold_lo;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hyst_fg <= 1'b0;
      hyst_y  <= '0;
    end else if (v2) begin
      hyst_fg <= raw_c;
      hyst_y  <= y2;
    end
  end
`else
  assign thr_sel = threshold;
`endif

  logic       v3, raw3;
  logic [9:0] x3, y3;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      raw3 <= 1'b0;
      x3   <= '0;
      y3   <= '0;
    end else begin
      v3   <= v2;
      raw3 <= raw_c;
      x3   <= x2;
      y3   <= y2;
    end
  end

  logic [RUN_W-1:0] run_cnt, run_next;
  logic [9:0]       prev_y;
  logic             new_line, mask_next, frame_start;
  logic [CNT_W-1:0] fg_run;

  always_comb begin
    new_line = (x3 == '0) || (y3 != prev_y);
    run_next = '0;
    if (raw3) begin
      if (new_line)
        run_next = RUN_W'(1);
      else if (run_cnt == RUN_MAX)
        run_next = RUN_MAX;
      else
        run_next = run_cnt + 1'b1;
    end
    mask_next   = !(run_next >= RUN_MAX);
    frame_start = v3 && (x3 == '0) && (y3 == '0);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      valid          <= 1'b0;
      mask           <= 1'b1;
      mask_x         <= '0;
      mask_y         <= '0;
      run_cnt        <= '0;
      prev_y         <= '0;
      fg_run         <= '0;
      fg_count_frame <= '0;
      frame_done     <= 1'b0;
    end else begin
      valid      <= v3;
      frame_done <= frame_start;
      if (v3) begin
        mask    <= mask_next;
        mask_x  <= x3;
        mask_y  <= y3;
        run_cnt <= run_next;
        prev_y  <= y3;
        if (frame_start) begin
          fg_count_frame <= fg_run;
          fg_run         <= {{(CNT_W-1){1'b0}}, ~mask_next};
        end else if (!mask_next && (fg_run != CNT_MAX)) begin
          fg_run <= fg_run + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mask_generator_pipe.sv
// Directed testbench for mask_generator_pipe; expected values are hand-computed per scenario.
// Builds with or without MASK_HYST_EN.
module tb_mask_generator_pipe;
  localparam int RB_W = 5, G_W = 6, MIN_RUN = 2, CNT_W = 20;

  logic             clk_25 = 1'b0;
  logic             rst_n  = 1'b0;
  logic [31:0]      threshold = '0;
`ifdef MASK_HYST_EN
  logic [31:0]      threshold_lo = '0;
`endif
  logic             read = 1'b0;
  logic [9:0]       sync_x = '0, sync_y = '0;
  logic [RB_W-1:0]  ccd_r = '0, ccd_b = '0, dvi_r = '0, dvi_b = '0;
  logic [G_W-1:0]   ccd_g = '0, dvi_g = '0;
  logic             valid, mask, frame_done;
  logic [9:0]       mask_x, mask_y;
  logic [CNT_W-1:0] fg_count_frame;

  int n_vec = 0;
  int n_err = 0;

  mask_generator_pipe #(.RB_W(RB_W), .G_W(G_W), .MIN_RUN(MIN_RUN), .CNT_W(CNT_W)) dut (
    .clk_25(clk_25), .rst_n(rst_n), .threshold(threshold),
`ifdef MASK_HYST_EN
    .threshold_lo(threshold_lo),
`endif
    .read(read), .sync_x(sync_x), .sync_y(sync_y),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b),
    .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .valid(valid), .mask(mask), .mask_x(mask_x), .mask_y(mask_y),
    .fg_count_frame(fg_count_frame), .frame_done(frame_done)
  );

  always #20 clk_25 = ~clk_25;

  logic q_mask[$];
  int   q_x[$];
  int   q_y[$];

  always @(negedge clk_25) begin
    if (rst_n && valid) begin
      q_mask.push_back(mask);
      q_x.push_back(int'(mask_x));
      q_y.push_back(int'(mask_y));
    end
  end

  // Reference is r=10,g=30,b=10; dr/dg are the ccd offsets (subtracted when neg=1).
  task automatic send(input int x, input int y, input int dr, input int dg, input bit neg);
    @(negedge clk_25);
    read   = 1'b1;
    sync_x = 10'(x);
    sync_y = 10'(y);
    dvi_r  = 5'd10;
    dvi_b  = 5'd10;
    dvi_g  = 6'd30;
    ccd_b  = 5'd10;
    ccd_r  = neg ? 5'(10 - dr) : 5'(10 + dr);
    ccd_g  = neg ? 6'(30 - dg) : 6'(30 + dg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_25);
      read = 1'b0;
    end
  endtask

  task automatic clear_q();
    q_mask.delete();
    q_x.delete();
    q_y.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25);
    n_vec++;
    if (valid !== 1'b0 || mask !== 1'b1 || mask_x !== 10'd0 || mask_y !== 10'd0 ||
        fg_count_frame !== '0 || frame_done !== 1'b0)
      begin
        n_err++;
        $display("FAIL reset_values: valid=%b mask=%b x=%0d y=%0d cnt=%0d done=%b, want 0 1 0 0 0 0",
                 valid, mask, mask_x, mask_y, fg_count_frame, frame_done);
      end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_latency();
    threshold = 32'd0;
    send(5, 7, 0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_25);
      read = 1'b0;
      n_vec++;
      if (valid !== (i == 4)) begin
        n_err++;
        $display("FAIL latency_cycle%0d: valid=%b, want %b", i, valid, (i == 4));
      end
    end
    n_vec++;
    if (mask !== 1'b1 || mask_x !== 10'd5 || mask_y !== 10'd7) begin
      n_err++;
      $display("FAIL latency_pixel: mask=%b x=%0d y=%0d, want 1 5 7", mask, mask_x, mask_y);
    end
    idle(3);
  endtask

  task automatic test_run_filter();
    int   gd[6]  = '{0, 0, 20, 20, 20, 0};
    logic exp[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    threshold = 32'd100;
    clear_q();
    for (int i = 0; i < 6; i++) send(i, 1, 0, gd[i], i == 3);
    idle(7);
    n_vec++;
    if (q_mask.size() != 6) begin
      n_err++;
      $display("FAIL run_count: got %0d outputs, want 6", q_mask.size());
    end
    for (int i = 0; i < 6 && i < q_mask.size(); i++) begin
      n_vec++;
      if (q_mask[i] !== exp[i] || q_x[i] != i || q_y[i] != 1) begin
        n_err++;
        $display("FAIL run_x%0d: mask=%b at (%0d,%0d), want %b at (%0d,1)",
                 i, q_mask[i], q_x[i], q_y[i], exp[i], i);
      end
    end
  endtask

  task automatic test_line_boundary();
    int px[6] = '{8, 9, 0, 1, 5, 6};
    int py[6] = '{3, 3, 4, 4, 5, 6};
    int gd[6] = '{0, 20, 20, 0, 20, 20};
    clear_q();
    for (int i = 0; i < 6; i++) send(px[i], py[i], 0, gd[i], 1'b0);
    idle(7);
    n_vec++;
    if (q_mask.size() != 6) begin
      n_err++;
      $display("FAIL line_count: got %0d outputs, want 6", q_mask.size());
    end
    for (int i = 0; i < 6 && i < q_mask.size(); i++) begin
      n_vec++;
      if (q_mask[i] !== 1'b1 || q_x[i] != px[i] || q_y[i] != py[i]) begin
        n_err++;
        $display("FAIL line_px%0d: mask=%b at (%0d,%0d), want 1 at (%0d,%0d)",
                 i, q_mask[i], q_x[i], q_y[i], px[i], py[i]);
      end
    end
  endtask

  task automatic test_frame_count();
    int  exp_cnt[3] = '{2, 0, 37};
    bit  found;
    threshold = 32'd100;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        for (int x = 0; x < 20; x++) send(x, 1, 0, 20, 1'b0);
        for (int x = 0; x < 19; x++) send(x, 2, 0, 20, 1'b1);
      end
      send(0, 0, 0, 20, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk_25);
        read = 1'b0;
        if (frame_done) found = 1'b1;
      end
      n_vec++;
      if (!found) begin
        n_err++;
        $display("FAIL frame%0d_done: no frame_done within 8 cycles, want pulse", f);
      end else if (fg_count_frame !== CNT_W'(exp_cnt[f])) begin
        n_err++;
        $display("FAIL frame%0d_count: fg_count_frame=%0d, want %0d", f, fg_count_frame, exp_cnt[f]);
      end
      @(negedge clk_25);
      n_vec++;
      if (frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL frame%0d_pulse: frame_done=%b one cycle later, want 0", f, frame_done);
      end
      idle(2);
    end
  endtask

  task automatic test_threshold_boundary();
    logic exp[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_q();
    threshold = 32'd400;
    for (int x = 0; x < 4; x++) send(x, 8, 0, 20, 1'b0);
    idle(6);
    threshold = 32'd399;
    for (int x = 0; x < 4; x++) send(x, 10, 0, 20, 1'b1);
    idle(7);
    n_vec++;
    if (q_mask.size() != 8) begin
      n_err++;
      $display("FAIL thr_count: got %0d outputs, want 8", q_mask.size());
    end
    for (int i = 0; i < 8 && i < q_mask.size(); i++) begin
      n_vec++;
      if (q_mask[i] !== exp[i]) begin
        n_err++;
        $display("FAIL thr_px%0d: mask=%b at (%0d,%0d), want %b", i, q_mask[i], q_x[i], q_y[i], exp[i]);
      end
    end
  endtask

  // Sums 500, 200, 200, 36 on one line with threshold 400 / threshold_lo 100.
  task automatic test_hysteresis();
    int   dr[4] = '{5, 1, 1, 0};
    int   dg[4] = '{20, 14, 14, 6};
`ifdef MASK_HYST_EN
    logic exp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    threshold_lo = 32'd100;
`else
    logic exp[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    threshold = 32'd400;
    clear_q();
    for (int i = 0; i < 4; i++) send(i + 1, 9, dr[i], dg[i], i == 2);
    idle(7);
    n_vec++;
    if (q_mask.size() != 4) begin
      n_err++;
      $display("FAIL hyst_count: got %0d outputs, want 4", q_mask.size());
    end
    for (int i = 0; i < 4 && i < q_mask.size(); i++) begin
      n_vec++;
      if (q_mask[i] !== exp[i] || q_x[i] != i + 1) begin
        n_err++;
        $display("FAIL hyst_px%0d: mask=%b x=%0d, want %b x=%0d", i, q_mask[i], q_x[i], exp[i], i + 1);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    threshold = 32'd100;
    clear_q();
    send(3, 12, 0, 20, 1'b0);
    send(4, 12, 0, 20, 1'b0);
    send(5, 12, 0, 20, 1'b0);
    @(negedge clk_25);
    read  = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (valid !== 1'b0 || mask !== 1'b1 || mask_x !== 10'd0 || mask_y !== 10'd0 ||
        fg_count_frame !== '0 || frame_done !== 1'b0)
      begin
        n_err++;
        $display("FAIL midreset_values: valid=%b mask=%b x=%0d y=%0d cnt=%0d done=%b, want 0 1 0 0 0 0",
                 valid, mask, mask_x, mask_y, fg_count_frame, frame_done);
      end
    @(negedge clk_25);
    rst_n = 1'b1;
    idle(8);
    n_vec++;
    if (q_mask.size() != 0) begin
      n_err++;
      $display("FAIL midreset_flush: %0d outputs after reset, want 0", q_mask.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_run_filter();
    test_line_boundary();
    test_frame_count();
    test_threshold_boundary();
    test_hysteresis();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
